// File: rtl/tp2_ej10_if.sv
// Bundle for the tp2_ej10 classifier: five input bits {a,b,c,d,e} and three flags {p,x,t}.
// The master drives the input word; the slave (the classifier) drives the flags.
interface tp2_ej10_if;
  logic a;
  logic b;
  logic c;
  logic d;
  logic e;
  logic p;
  logic x;
  logic t;

  modport master (
    output a, b, c, d, e,
    input  p, x, t
  );

  modport slave (
    input  a, b, c, d, e,
    output p, x, t
  );
endinterface

// File: rtl/tp2_ej10.sv
// Five-input parity / majority / prime classifier with registered flags.
// Optional input register stage: define TP2_EJ10_INREG_EN (adds one clk of latency).
module tp2_ej10 (
  input logic        clk,
  input logic        rst_n,
  tp2_ej10_if.slave  bus
);

  // One bit per code 0..31, set where the code is prime (2,3,5,7,11,13,17,19,23,29,31).
  localparam logic [31:0] PrimeMask = 32'hA08A_28AC;

  logic [4:0] v_in;
  logic [4:0] v;
  logic [2:0] ones;
  logic       p_n;
  logic       x_n;
  logic       t_n;
  logic       p_q;
  logic       x_q;
  logic       t_q;

  assign v_in = {bus.a, bus.b, bus.c, bus.d, bus.e};

`ifdef TP2_EJ10_INREG_EN
  logic [4:0] v_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q <= v_in;
    end
  end

  assign v = v_q;
`else
  assign v = v_in;
`endif

  always_comb begin
    ones = '0;
    for (int i = 0; i < 5; i++) begin
      ones = ones + {2'b00, v[i]};
    end
  end

  assign p_n = ^v;
  assign x_n = (ones >= 3'd3);
  assign t_n = PrimeMask[v];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q <= 1'b0;
      x_q <= 1'b0;
      t_q <= 1'b0;
    end else begin
      p_q <= p_n;
      x_q <= x_n;
      t_q <= t_n;
    end
  end

  assign bus.p = p_q;
  assign bus.x = x_q;
  assign bus.t = t_q;

endmodule

// File: tb/tb_tp2_ej10.sv
// Self-checking bench for tp2_ej10: per-cycle model compare plus directed literal checks.
// Honours TP2_EJ10_INREG_EN to match the DUT build's latency.
module tb_tp2_ej10;

`ifdef TP2_EJ10_INREG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  tp2_ej10_if bus ();

  tp2_ej10 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags from first principles: count ones, trial-divide for primality.
  function automatic logic [2:0] ref_flags(input int v);
    int ones;
    bit prime;
    ones = 0;
    for (int i = 0; i < 5; i++) ones += (v >> i) & 1;
    prime = (v >= 2);
    for (int k = 2; k < v; k++) if (v % k == 0) prime = 0;
    return {ones % 2 == 1, ones >= 3, prime};
  endfunction

  // Model history: word seen by the logic on each edge, with reset forcing zero.
  int         hist_v   [$];
  bit         hist_rst [$];
  logic [2:0] exp_flags;
  bit         model_valid;

  initial begin
    exp_flags   = 3'b000;
    model_valid = 0;
  end

  always @(posedge clk) begin
    int cur;
    cur = {bus.a, bus.b, bus.c, bus.d, bus.e};
    hist_v.push_back(cur);
    hist_rst.push_back(!rst_n);
    if (hist_v.size() > Lat) begin
      void'(hist_v.pop_front());
      void'(hist_rst.pop_front());
    end
    // Output clears on a reset edge; otherwise it shows the word sampled Lat-1 edges earlier,
    // unless that word went into a register that was itself being cleared.
    if (!rst_n) begin
      exp_flags <= 3'b000;
    end else if (hist_v.size() < Lat || hist_rst[0]) begin
      exp_flags <= ref_flags(0);
    end else begin
      exp_flags <= ref_flags(hist_v[0]);
    end
    model_valid <= 1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if ({bus.p, bus.x, bus.t} !== exp_flags) begin
        failures++;
        $display("FAIL model_cmp t=%0t got pxt=%b expected pxt=%b", $time,
                 {bus.p, bus.x, bus.t}, exp_flags);
      end
    end
  end

  task automatic drive(input int v);
    logic [4:0] w;
    w = v[4:0];
    {bus.a, bus.b, bus.c, bus.d, bus.e} = w;
  endtask

  task automatic check_lit(input string name, input logic [2:0] exp);
    checks++;
    if ({bus.p, bus.x, bus.t} !== exp) begin
      failures++;
      $display("FAIL %s got pxt=%b expected pxt=%b", name, {bus.p, bus.x, bus.t}, exp);
    end
  endtask

  // Present v, let it propagate through the pipeline, then check at the next falling edge.
  task automatic apply_check(input string name, input int v, input logic [2:0] exp);
    @(negedge clk);
    drive(v);
    repeat (Lat) @(posedge clk);
    @(negedge clk);
    check_lit(name, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(31);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_lit("reset_hold", 3'b000);

    // Sweep one code per clock; the per-cycle compare covers every response.
    rst_n = 1'b1;
    for (int v = 0; v < 32; v++) begin
      drive(v);
      @(negedge clk);
    end

    apply_check("v7",  7,  3'b111);
    apply_check("v9",  9,  3'b000);
    apply_check("v2",  2,  3'b101);
    apply_check("v24", 24, 3'b000);
    apply_check("v28", 28, 3'b110);
    apply_check("v30", 30, 3'b010);
    apply_check("v31", 31, 3'b111);
    apply_check("v0",  0,  3'b000);
    apply_check("v1",  1,  3'b100);

    // Reset mid-stream at V=19.
    apply_check("v19_pre", 19, 3'b111);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_lit("midreset_clear", 3'b000);
    rst_n = 1'b1;
    repeat (Lat) @(posedge clk);
    @(negedge clk);
    check_lit("midreset_recover", 3'b111);

    // Short back-to-back burst after recovery.
    for (int v = 31; v >= 20; v--) begin
      drive(v);
      @(negedge clk);
    end
    repeat (Lat + 1) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
